// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding, default bus
// widths and the wait-counter sizing helper.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Counter must hold 0..limit; a disabled limit still gets a 1-bit counter.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus bundle between the requester (master) and a completer (slave).
interface apb_master_ctrl_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_W,
   parameter int DATA_WIDTH = APB_DATA_W
);

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready and flags the cycle in which
// the wait limit would be reached without the completer responding.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (tick && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   // This tick is the one that brings the count up to the limit.
   assign expire = (TIMEOUT_CYCLES > 0) && tick && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS on the bus,
// and returns a single-cycle completion with read data, error and timeout.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_W,
   parameter int DATA_WIDTH     = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   apb_master_ctrl_if.master     apb
);

   apb_state_e state, state_nxt;

   logic                  accept;
   logic                  done_ok;
   logic                  done_to;
   logic                  wait_tick;
   logic                  wait_clear;
   logic                  wait_expire;

   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            // A ready completer wins over a limit reached in the same cycle.
            if (apb.pready) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_expire) begin
               done_to   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign cmd_ready   = (state == IDLE);
   assign apb.psel    = (state != IDLE);
   assign apb.penable = (state == ACCESS);
   assign apb.pwrite  = write_q;
   assign apb.paddr   = addr_q;
   assign apb.pwdata  = wdata_q;

   assign wait_clear = (state == SETUP);
   assign wait_tick  = (state == ACCESS) && !apb.pready;

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (wait_clear),
      .tick   (wait_tick),
      .expire (wait_expire)
   );

   // Request is captured once at accept and held for the whole transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         write_q <= cmd_write;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_write ? cmd_wdata : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= done_ok || done_to;
         if (done_ok) begin
            rsp_rdata   <= write_q ? '0 : apb.prdata;
            rsp_err     <= apb.pslverr;
            rsp_timeout <= 1'b0;
         end else if (done_to) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule
